// File: rtl/song_reader_pkg.sv
// rtl/song_reader_pkg.sv - shared widths, FSM encoding and song ROM image for song_reader
package song_reader_pkg;

    localparam int NOTE_W    = 6;
    localparam int DUR_W     = 6;
    localparam int SONG_BITS = 2;
    localparam int NOTE_BITS = 5;
    localparam int ADDR_W    = SONG_BITS + NOTE_BITS;
    localparam int WORD_W    = NOTE_W + DUR_W;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_WAIT_ROM = 3'd2;
    localparam logic [2:0] S_LOAD     = 3'd3;
    localparam logic [2:0] S_GUARD    = 3'd4;
    localparam logic [2:0] S_PLAY     = 3'd5;
    localparam logic [2:0] S_ADVANCE  = 3'd6;

    localparam logic [DUR_W-1:0]     END_MARKER_DUR = '0;
    localparam logic [NOTE_BITS-1:0] IDX_LAST       = '1;

    // Song ROM image, word = {note, duration}:
    //   song 0: note 20+i, 12 beats
    //   song 1: note i (entry 0 is a rest), 1 beat
    //   song 2: entries 0-4 note 10+i / 3 beats, entry 5 end marker, rest filler
    //   song 3: note 45-i, 7 beats
    function automatic logic [WORD_W-1:0] song_word(input logic [ADDR_W-1:0] addr);
        logic [NOTE_BITS-1:0] i;
        logic [NOTE_W-1:0]    n;
        logic [DUR_W-1:0]     d;
        i = addr[NOTE_BITS-1:0];
        case (addr[ADDR_W-1:NOTE_BITS])
            2'd0: begin
                n = NOTE_W'(20) + NOTE_W'(i);
                d = DUR_W'(12);
            end
            2'd1: begin
                n = NOTE_W'(i);
                d = DUR_W'(1);
            end
            2'd2: begin
                if (i < 5'd5) begin
                    n = NOTE_W'(10) + NOTE_W'(i);
                    d = DUR_W'(3);
                end else if (i == 5'd5) begin
                    n = '0;
                    d = END_MARKER_DUR;
                end else begin
                    n = NOTE_W'(1);
                    d = DUR_W'(1);
                end
            end
            default: begin
                n = NOTE_W'(45) - NOTE_W'(i);
                d = DUR_W'(7);
            end
        endcase
        return {n, d};
    endfunction

endpackage

// File: rtl/song_reader_if.sv
// rtl/song_reader_if.sv - control/player handshake bundle around song_reader
interface song_reader_if;
    import song_reader_pkg::*;

    logic                 play;
    logic [SONG_BITS-1:0] song;
    logic                 note_done;
    logic [NOTE_W-1:0]    note;
    logic [DUR_W-1:0]     duration;
    logic                 new_note;
    logic                 song_done;

    modport master (
        output play, song, note_done,
        input  note, duration, new_note, song_done
    );

    modport slave (
        input  play, song, note_done,
        output note, duration, new_note, song_done
    );
endinterface

// File: rtl/dffr.sv
// rtl/dffr.sv - register with synchronous active-high clear
module dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // capture d every cycle, clear on reset
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end
endmodule

// File: rtl/dffre.sv
// rtl/dffre.sv - register with synchronous active-high clear and load enable
module dffre #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // capture d when enabled, clear on reset
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/song_rom.sv
// rtl/song_rom.sv - synchronous-read song ROM, one cycle latency
module song_rom
    import song_reader_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] dout
);
    // registered read of the song image
    always_ff @(posedge clk) begin
        dout <= song_word(addr);
    end
endmodule

// File: rtl/song_reader.sv
// rtl/song_reader.sv - walks a song ROM and hands notes one at a time to the note player
module song_reader
    import song_reader_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    song_reader_if.slave bus
);
    logic [2:0]           state;
    logic [2:0]           state_nx;
    logic [NOTE_BITS-1:0] note_idx;
    logic [NOTE_BITS-1:0] idx_nx;
    logic                 idx_en;
    logic [SONG_BITS-1:0] song_q;
    logic [WORD_W-1:0]    rom_dout;
    logic [WORD_W-1:0]    word_q;
    logic [DUR_W-1:0]     rom_dur;
    logic                 rom_end;
    logic                 end_q;
    logic                 song_chg;
    logic                 load_en;
    logic                 strobe;
    logic                 done;

    assign rom_dur  = rom_dout[DUR_W-1:0];
    assign rom_end  = (rom_dur == END_MARKER_DUR);
    assign song_chg = (bus.song != song_q);
    // ROM word is valid in WAIT_ROM; capture it on the way into LOAD
    assign load_en  = (state == S_WAIT_ROM) && bus.play && !song_chg;

    song_rom u_rom (
        .clk  (clk),
        .addr ({song_q, note_idx}),
        .dout (rom_dout)
    );

    dffr #(.W(3)) u_state (
        .clk(clk), .reset(reset), .d(state_nx), .q(state)
    );

    dffre #(.W(NOTE_BITS)) u_idx (
        .clk(clk), .reset(reset), .en(idx_en), .d(idx_nx), .q(note_idx)
    );

    dffr #(.W(SONG_BITS)) u_song (
        .clk(clk), .reset(reset), .d(bus.song), .q(song_q)
    );

    // an end marker never overwrites the last real note on the outputs
    dffre #(.W(WORD_W)) u_word (
        .clk(clk), .reset(reset), .en(load_en && !rom_end), .d(rom_dout), .q(word_q)
    );

    dffre #(.W(1)) u_end (
        .clk(clk), .reset(reset), .en(load_en), .d(rom_end), .q(end_q)
    );

    // next-state, index update and strobes; a song change overrides every non-idle step
    always_comb begin
        state_nx = state;
        idx_nx   = note_idx;
        idx_en   = 1'b0;
        strobe   = 1'b0;
        done     = 1'b0;
        if (song_chg && (state != S_IDLE)) begin
            state_nx = S_FETCH;
            idx_nx   = '0;
            idx_en   = 1'b1;
        end else begin
            case (state)
                S_IDLE:     if (bus.play) state_nx = S_FETCH;
                S_FETCH:    if (bus.play) state_nx = S_WAIT_ROM;
                S_WAIT_ROM: if (bus.play) state_nx = S_LOAD;
                S_LOAD: begin
                    if (bus.play) begin
                        if (end_q) begin
                            done     = 1'b1;
                            idx_nx   = '0;
                            idx_en   = 1'b1;
                            state_nx = S_IDLE;
                        end else begin
                            strobe   = 1'b1;
                            state_nx = S_GUARD;
                        end
                    end
                end
                // the player's done level from the previous note is still high here
                S_GUARD:    if (bus.play) state_nx = S_PLAY;
                // the player pauses its own timer, so done is accepted even when paused
                S_PLAY:     if (bus.note_done) state_nx = S_ADVANCE;
                S_ADVANCE: begin
                    if (bus.play) begin
                        idx_nx = note_idx + 1'b1;
                        idx_en = 1'b1;
                        if (note_idx == IDX_LAST) begin
                            done     = 1'b1;
                            state_nx = S_IDLE;
                        end else begin
                            state_nx = S_FETCH;
                        end
                    end
                end
                default:    state_nx = S_IDLE;
            endcase
        end
    end

    assign bus.note      = word_q[WORD_W-1:DUR_W];
    assign bus.duration  = word_q[DUR_W-1:0];
    assign bus.new_note  = strobe && !reset;
    assign bus.song_done = done && !reset;
endmodule

// File: tb/tb_song_reader.sv
// tb/tb_song_reader.sv - directed self-checking bench for song_reader
module tb_song_reader;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    song_reader_if bus ();

    song_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_strobe(input string tag, input int max, input int exp_gap);
        int n;
        bit seen_done;
        n = 0;
        seen_done = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (bus.song_done) seen_done = 1'b1;
        end while (!bus.new_note && n < max);
        check({tag, " gap"}, n, exp_gap);
        check({tag, " no song_done"}, 32'(seen_done), 0);
    endtask

    task automatic check_note(input string tag, input int n, input int d);
        check({tag, " new_note"}, 32'(bus.new_note), 1);
        check({tag, " note"}, 32'(bus.note), n);
        check({tag, " duration"}, 32'(bus.duration), d);
    endtask

    task automatic pulse_done(input string tag, input int exp_done);
        step();
        step();
        bus.note_done = 1'b1;
        step();
        check(tag, 32'(bus.song_done), exp_done);
        bus.note_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.play      = 1'b0;
        bus.song      = '0;
        bus.note_done = 1'b0;
        repeat (2) step();
        check("reset outputs", {18'd0, bus.note, bus.duration, bus.new_note, bus.song_done}, 0);

        reset = 1'b0;
        bus.play = 1'b1;
        bus.note_done = 1'b1;
        wait_strobe("first", 8, 3);
        check_note("s0 entry0", 20, 12);
        step();
        check("single-cycle strobe", 32'(bus.new_note), 0);
        wait_strobe("guard", 10, 5);
        check_note("s0 entry1", 21, 12);
        for (int k = 2; k <= 7; k++) begin
            wait_strobe("s0", 10, 6);
            check_note("s0 entry", 20 + k, 12);
        end

        bus.note_done = 1'b0;
        step();
        step();
        bus.song = 2'd3;
        bus.note_done = 1'b1;
        wait_strobe("song change", 8, 3);
        check_note("s3 entry0", 45, 7);

        bus.note_done = 1'b0;
        bus.song = 2'd1;
        wait_strobe("to song1", 8, 3);
        for (int k = 0; k < 32; k++) begin
            check_note("s1 entry", k, 1);
            pulse_done("s1 song_done", (k == 31) ? 1 : 0);
            if (k < 31) wait_strobe("s1", 8, 3);
        end
        step();
        check("s1 song_done one cycle", 32'(bus.song_done), 0);
        wait_strobe("s1 restart", 8, 3);
        check_note("s1 restart", 0, 1);

        bus.song = 2'd2;
        wait_strobe("to song2", 8, 3);
        for (int k = 0; k < 5; k++) begin
            check_note("s2 entry", 10 + k, 3);
            pulse_done("s2 song_done", 0);
            if (k < 4) wait_strobe("s2", 8, 3);
        end
        step();
        step();
        step();
        check("end marker no strobe", 32'(bus.new_note), 0);
        check("end marker song_done", 32'(bus.song_done), 1);
        check("end marker note held", 32'(bus.note), 14);
        check("end marker duration held", 32'(bus.duration), 3);
        step();
        check("s2 song_done one cycle", 32'(bus.song_done), 0);

        step();
        step();
        bus.play = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("pause no strobe", 32'(bus.new_note), 0);
        end
        bus.play = 1'b1;
        step();
        check_note("after pause", 10, 3);

        step();
        step();
        reset = 1'b1;
        step();
        check("reset in PLAY", {18'd0, bus.note, bus.duration, bus.new_note, bus.song_done}, 0);

        reset = 1'b0;
        wait_strobe("post reset", 8, 3);
        check_note("post reset", 10, 3);
        reset = 1'b1;
        #1;
        check("strobe masked by reset", 32'(bus.new_note), 0);
        step();
        check("reset in LOAD", {18'd0, bus.note, bus.duration, bus.new_note, bus.song_done}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
